// File: rtl/rx_serial.sv
// 8N1 UART receiver: 2-flop synchronised rx, mid-bit sampling, one-cycle byte/frame-error strobes.
// Optional build macro RX_MAJORITY_VOTE_EN: 2-of-3 majority around each sample point, strobes 1 cycle later.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling stop bit, emitting byte or frame error
// BRK   | stop bit was low; wait for the line to return high
module rx_serial #(
    parameter int RCONST = 108
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rbyte,
    output logic       onebyte,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (RCONST > 1) ? $clog2(RCONST) : 1;
    localparam logic [CW-1:0] BIT_END = CW'(RCONST - 1);
`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] START_END = CW'(RCONST / 2);
`else
    localparam logic [CW-1:0] START_END = CW'(RCONST / 2 - 1);
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t          state;
    logic            meta;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [2:0]      bitn;
    logic [7:0]      sh;
    logic            samp;

`ifdef RX_MAJORITY_VOTE_EN
    // hist holds rxs from the two cycles before the decision cycle
    logic [1:0] hist;

    always_ff @(posedge clk100) begin
        if (reset) hist <= 2'b11;
        else       hist <= {hist[0], rxs};
    end

    assign samp = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
    assign samp = rxs;
`endif

    always_ff @(posedge clk100) begin
        if (reset) begin
            state     <= IDLE;
            meta      <= 1'b1;
            rxs       <= 1'b1;
            cnt       <= '0;
            bitn      <= '0;
            sh        <= '0;
            rbyte     <= '0;
            onebyte   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            meta      <= rx;
            rxs       <= meta;
            onebyte   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    busy <= 1'b0;
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == START_END) begin
                        cnt <= '0;
                        if (!samp) begin
                            state <= DATA;
                            bitn  <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        sh  <= {samp, sh[7:1]};
                        if (bitn == 3'd7) state <= STOP;
                        else              bitn  <= bitn + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        if (samp) begin
                            // back to IDLE at mid stop bit so the next start edge is never missed
                            rbyte   <= sh;
                            onebyte <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BRK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_serial.sv
// Directed plus randomized bench for rx_serial: serial frames driven cycle by cycle,
// received bytes collected into a queue and compared with the bytes that were sent.
module tb_rx_serial;

    localparam int R = 108;
    localparam int H = R / 2;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int MV = 1;
`else
    localparam int MV = 0;
`endif
    // rx falling edge to first onebyte cycle, in clk100 cycles
    localparam int LAT = 2 + H + 9 * R + 1 + MV;

    logic       clk100 = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rbyte;
    logic       onebyte;
    logic       frame_err;
    logic       busy;

    rx_serial #(.RCONST(R)) dut (
        .clk100    (clk100),
        .reset     (reset),
        .rx        (rx),
        .rbyte     (rbyte),
        .onebyte   (onebyte),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk100 = ~clk100;

    int cyc = 0;
    always @(posedge clk100) cyc <= cyc + 1;

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int  ncomp = 0;
    int  nfail = 0;
    int  start_cyc = 0;
    int  last_ob_cyc = 0;
    int  fe_cnt = 0;
    int  both_cnt = 0;
    int  long_cnt = 0;
    bit  ob_prev = 1'b0;
    bit  busy_seen = 1'b0;

    always @(negedge clk100) begin
        if (onebyte) begin
            obs_q.push_back(rbyte);
            if (!ob_prev) last_ob_cyc = cyc;
            else          long_cnt++;
        end
        ob_prev = onebyte;
        if (frame_err) fe_cnt++;
        if (onebyte && frame_err) both_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk100);
            #1;
        end
    endtask

    // Drives the first nslots cycles of an 8N1 frame; a complete frame is expected back.
    // glitch inverts rx for one cycle at the middle of every bit.
    task automatic send_frame(input logic [7:0] b, input bit glitch, input int nslots);
        logic [9:0] f;
        logic       v;
        f = {1'b1, b, 1'b0};
        start_cyc = cyc;
        for (int s = 0; s < nslots; s++) begin
            v = f[s / R];
            if (glitch && (s % R) == H) v = ~v;
            rx = v;
            idle(1);
        end
        rx = 1'b1;
        if (nslots == 10 * R) exp_q.push_back(b);
    endtask

    task automatic check_queue(input string tag);
        int n;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int fe0;
        int gap;
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk100);
        #1;
        reset = 1'b0;
        chk("rst_rbyte", 32'(rbyte), 32'h0);
        chk("rst_onebyte", 32'(onebyte), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        idle(5);

        // single byte, with latency
        send_frame(8'h41, 1'b0, 10 * R);
        idle(5);
        chk("a_latency", 32'(last_ob_cyc - start_cyc), 32'(LAT));
        chk("a_rbyte", 32'(rbyte), 32'h41);
        check_queue("a");
        chk("a_fe", 32'(fe_cnt), 32'h0);
        chk("a_busy", 32'(busy), 32'h0);

        // back-to-back frames, no idle gap
        send_frame(8'h41, 1'b0, 10 * R);
        send_frame(8'h44, 1'b0, 10 * R);
        send_frame(8'h54, 1'b0, 10 * R);
        send_frame(8'h0D, 1'b0, 10 * R);
        idle(5);
        check_queue("b2b");
        chk("b2b_fe", 32'(fe_cnt), 32'h0);

        // short low glitch from idle
        busy_seen = 1'b0;
        rx = 1'b0;
        idle(30);
        rx = 1'b1;
        idle(R);
        check_queue("glitch");
        chk("glitch_fe", 32'(fe_cnt), 32'h0);
        chk("glitch_busy_seen", 32'(busy_seen), 32'h1);
        chk("glitch_busy", 32'(busy), 32'h0);
        chk("glitch_rbyte", 32'(rbyte), 32'h0D);

        // line break: 20 bit periods low
        fe0 = fe_cnt;
        rx = 1'b0;
        idle(20 * R);
        chk("break_busy_held", 32'(busy), 32'h1);
        rx = 1'b1;
        idle(R);
        chk("break_fe", 32'(fe_cnt - fe0), 32'h1);
        check_queue("break");
        chk("break_rbyte", 32'(rbyte), 32'h0D);
        chk("break_busy", 32'(busy), 32'h0);
        send_frame(8'h55, 1'b0, 10 * R);
        idle(5);
        check_queue("after_break");
        chk("after_break_fe", 32'(fe_cnt - fe0), 32'h1);

        // reset during data bit 4, then a clean frame
        fe0 = fe_cnt;
        send_frame(8'hC3, 1'b0, 5 * R + 10);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("abort_rbyte", 32'(rbyte), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        idle(2 * R);
        check_queue("abort");
        chk("abort_fe", 32'(fe_cnt - fe0), 32'h0);
        send_frame(8'h3C, 1'b0, 10 * R);
        idle(5);
        chk("post_abort_latency", 32'(last_ob_cyc - start_cyc), 32'(LAT));
        chk("post_abort_rbyte", 32'(rbyte), 32'h3C);
        check_queue("post_abort");

        // random bytes with random idle gaps (including none)
        for (int i = 0; i < 10; i++) begin
            send_frame(8'($urandom), 1'b0, 10 * R);
            gap = int'($urandom_range(40, 0));
            if (gap > 0) idle(gap);
        end
        idle(5);
        check_queue("random");
        chk("random_fe", 32'(fe_cnt - fe0), 32'h0);

`ifdef RX_MAJORITY_VOTE_EN
        send_frame(8'hA5, 1'b1, 10 * R);
        idle(5);
        chk("mv_latency", 32'(last_ob_cyc - start_cyc), 32'(LAT));
        chk("mv_rbyte", 32'(rbyte), 32'hA5);
        check_queue("mv");
        chk("mv_fe", 32'(fe_cnt - fe0), 32'h0);
`endif

        chk("strobes_overlap", 32'(both_cnt), 32'h0);
        chk("onebyte_width", 32'(long_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
